// File: rtl/pu_tag_insert.sv
// pu_tag_insert: write side of the PU tag lookup path.
//   Takes insert/update/delete requests, hashes the key into two bucket
//   tables (table0 indexed by hash of key, table1 by hash of bit-reversed
//   key), scans the eight candidate slots, then issues the value-word and
//   bucket writes together in one WRITE cycle and reports a status.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   tag_ins_*                     request in (valid/ready/op/key/payload/pid)
//   tag_hash_table{0,1}_*         bucket read (rd/raddr, ack/rdata), write (wr/waddr/wdata)
//   tag_value_*                   value word read (rd/raddr, ack/rdata), write (wr/waddr/wdata)
//   tag_ins_status_*              one-cycle completion pulse with status and pid
//     status: 0 INSERTED, 1 UPDATED, 2 DELETED, 3 FULL, 4 NOT_FOUND

// Shared hash: 6-bit xor fold of the key, registered (one cycle latency).
module pu_tag_hash #(
  parameter int KEY_W = 32
) (
  input  logic             clk,
  input  logic [KEY_W-1:0] key,
  output logic [5:0]       hash_q
);
  logic [5:0] hash_d;
  always_comb begin
    hash_d = '0;
    for (int j = 0; j < 6; j++)
      for (int i = j; i < KEY_W; i += 6)
        hash_d[j] = hash_d[j] ^ key[i];
  end
  always_ff @(posedge clk) hash_q <= hash_d;
endmodule

module pu_tag_insert #(
  parameter  int KEY_W    = 32,
  parameter  int DEPTH_W  = 4,
  parameter  int HASH_W   = 4,
  parameter  int PAY_W    = 16,
  parameter  int PID_W    = 4,
  localparam int VADDR_W  = DEPTH_W + 3,
  localparam int ENTRY_W  = VADDR_W + HASH_W,
  localparam int BUCKET_W = 4 * ENTRY_W,
  localparam int VALUE_W  = KEY_W + PAY_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tag_ins_valid,
  output logic                tag_ins_ready,
  input  logic                tag_ins_op,
  input  logic [KEY_W-1:0]    tag_ins_key,
  input  logic [PAY_W-1:0]    tag_ins_payload,
  input  logic [PID_W-1:0]    tag_ins_pid,
  output logic                tag_hash_table0_rd,
  output logic [DEPTH_W-1:0]  tag_hash_table0_raddr,
  input  logic                tag_hash_table0_ack,
  input  logic [BUCKET_W-1:0] tag_hash_table0_rdata,
  output logic                tag_hash_table0_wr,
  output logic [DEPTH_W-1:0]  tag_hash_table0_waddr,
  output logic [BUCKET_W-1:0] tag_hash_table0_wdata,
  output logic                tag_hash_table1_rd,
  output logic [DEPTH_W-1:0]  tag_hash_table1_raddr,
  input  logic                tag_hash_table1_ack,
  input  logic [BUCKET_W-1:0] tag_hash_table1_rdata,
  output logic                tag_hash_table1_wr,
  output logic [DEPTH_W-1:0]  tag_hash_table1_waddr,
  output logic [BUCKET_W-1:0] tag_hash_table1_wdata,
  output logic                tag_value_rd,
  output logic [VADDR_W-1:0]  tag_value_raddr,
  input  logic                tag_value_ack,
  input  logic [VALUE_W-1:0]  tag_value_rdata,
  output logic                tag_value_wr,
  output logic [VADDR_W-1:0]  tag_value_waddr,
  output logic [VALUE_W-1:0]  tag_value_wdata,
  output logic                tag_ins_status_valid,
  output logic [2:0]          tag_ins_status,
  output logic [PID_W-1:0]    tag_ins_status_pid
);
  typedef enum logic [3:0] {
    S_IDLE, S_HASH, S_BRD, S_BWAIT, S_SCAN, S_VRD, S_VWAIT, S_WRITE, S_DONE
  } state_t;

  typedef struct packed {
    logic             op;
    logic [KEY_W-1:0] key;
    logic [PAY_W-1:0] payload;
    logic [PID_W-1:0] pid;
  } req_t;

  typedef logic [1:0][3:0][ENTRY_W-1:0] bkt_t;

  state_t     state_q, state_d;
  req_t       req_q, req_d;
  bkt_t       bkt_q, bkt_d, bkt_wdata;
  logic [1:0] got_q, got_d;
  logic [2:0] slot_q, slot_d, free_slot_q, free_slot_d, match_slot_q, match_slot_d;
  logic       free_vld_q, free_vld_d, match_q, match_d;
  logic [2:0] status_q, status_d;

  // hash[0] from key (table0 index), hash[1] from bit-reversed key (table1 index)
  logic [KEY_W-1:0]       key_t;
  logic [1:0][5:0]        hash;
  logic [1:0][DEPTH_W-1:0] idx;
  logic [1:0][HASH_W-1:0]  sig;

  always_comb begin
    for (int i = 0; i < KEY_W; i++) key_t[i] = req_q.key[KEY_W-1-i];
  end

  pu_tag_hash #(.KEY_W(KEY_W)) u_hash [1:0] (
    .clk    (clk),
    .key    ({key_t, req_q.key}),
    .hash_q (hash)
  );

  // Each table stores the other table's hash as signature.
  always_comb begin
    idx[0] = hash[0][DEPTH_W-1:0];
    idx[1] = hash[1][DEPTH_W-1:0];
    sig[0] = hash[1][HASH_W-1:0];
    sig[1] = hash[0][HASH_W-1:0];
  end

  // Current scan slot: slot_q[2] selects the table, [1:0] the slot.
  logic               cur_tbl, cur_hit, cur_rsv, key_eq;
  logic [ENTRY_W-1:0] cur_ent;
  logic [2:0]         tgt_slot;
  logic               tgt_tbl;
  logic [VADDR_W-1:0] tgt_addr;

  always_comb begin
    cur_tbl  = slot_q[2];
    cur_ent  = bkt_q[cur_tbl][slot_q[1:0]];
    cur_hit  = (cur_ent != '0) && (cur_ent[HASH_W-1:0] == sig[cur_tbl]);
    // value address 0 would encode as an all-zero (empty) entry
    cur_rsv  = (slot_q == 3'd0) && (idx[0] == '0);
    key_eq   = tag_value_rdata[VALUE_W-1 -: KEY_W] == req_q.key;
    tgt_slot = match_q ? match_slot_q : free_slot_q;
    tgt_tbl  = tgt_slot[2];
    tgt_addr = {tgt_tbl, idx[tgt_tbl], tgt_slot[1:0]};
    bkt_wdata = bkt_q;
    for (int t = 0; t < 2; t++)
      bkt_wdata[t][tgt_slot[1:0]] = req_q.op ? '0 : {tgt_addr, sig[t]};
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    bkt_d        = bkt_q;
    got_d        = got_q;
    slot_d       = slot_q;
    free_vld_d   = free_vld_q;
    free_slot_d  = free_slot_q;
    match_d      = match_q;
    match_slot_d = match_slot_q;
    status_d     = status_q;
    case (state_q)
      S_IDLE: if (tag_ins_valid) begin
        req_d.op      = tag_ins_op;
        req_d.key     = tag_ins_key;
        req_d.payload = tag_ins_payload;
        req_d.pid     = tag_ins_pid;
        state_d       = S_HASH;
      end
      S_HASH: state_d = S_BRD;
      S_BRD: begin
        got_d      = '0;
        slot_d     = '0;
        free_vld_d = 1'b0;
        match_d    = 1'b0;
        state_d    = S_BWAIT;
      end
      S_BWAIT: begin
        if (tag_hash_table0_ack && !got_q[0]) begin bkt_d[0] = tag_hash_table0_rdata; got_d[0] = 1'b1; end
        if (tag_hash_table1_ack && !got_q[1]) begin bkt_d[1] = tag_hash_table1_rdata; got_d[1] = 1'b1; end
        if (got_d == 2'b11) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (cur_hit) state_d = S_VRD;
        else begin
          if (cur_ent == '0 && !cur_rsv && !free_vld_q) begin
            free_vld_d  = 1'b1;
            free_slot_d = slot_q;
          end
          if (slot_q == 3'd7) state_d = S_WRITE;
          else                slot_d  = slot_q + 3'd1;
        end
      end
      S_VRD: state_d = S_VWAIT;
      S_VWAIT: if (tag_value_ack) begin
        if (key_eq) begin
          match_d      = 1'b1;
          match_slot_d = slot_q;
          state_d      = S_WRITE;
        end else if (slot_q == 3'd7) state_d = S_WRITE;
        else begin
          slot_d  = slot_q + 3'd1;
          state_d = S_SCAN;
        end
      end
      S_WRITE: begin
        if (req_q.op) status_d = match_q ? 3'd2 : 3'd4;
        else          status_d = match_q ? 3'd1 : (free_vld_q ? 3'd0 : 3'd3);
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;

  always_ff @(posedge clk) begin
    req_q        <= req_d;
    bkt_q        <= bkt_d;
    got_q        <= got_d;
    slot_q       <= slot_d;
    free_vld_q   <= free_vld_d;
    free_slot_q  <= free_slot_d;
    match_q      <= match_d;
    match_slot_q <= match_slot_d;
    status_q     <= status_d;
  end

  logic in_wr, do_val, do_bkt;
  always_comb begin
    in_wr  = state_q == S_WRITE;
    do_val = match_q || (!req_q.op && free_vld_q);
    do_bkt = req_q.op ? match_q : (!match_q && free_vld_q);
  end

  assign tag_ins_ready         = state_q == S_IDLE;
  assign tag_hash_table0_rd    = state_q == S_BRD;
  assign tag_hash_table1_rd    = state_q == S_BRD;
  assign tag_hash_table0_raddr = idx[0];
  assign tag_hash_table1_raddr = idx[1];
  assign tag_hash_table0_wr    = in_wr && do_bkt && !tgt_tbl;
  assign tag_hash_table1_wr    = in_wr && do_bkt && tgt_tbl;
  assign tag_hash_table0_waddr = idx[0];
  assign tag_hash_table1_waddr = idx[1];
  assign tag_hash_table0_wdata = bkt_wdata[0];
  assign tag_hash_table1_wdata = bkt_wdata[1];
  assign tag_value_rd          = state_q == S_VRD;
  assign tag_value_raddr       = cur_ent[ENTRY_W-1 -: VADDR_W];
  assign tag_value_wr          = in_wr && do_val;
  assign tag_value_waddr       = tgt_addr;
  assign tag_value_wdata       = {req_q.key, req_q.op ? {PAY_W{1'b0}} : req_q.payload};
  assign tag_ins_status_valid  = state_q == S_DONE;
  assign tag_ins_status        = status_q;
  assign tag_ins_status_pid    = req_q.pid;

  logic unused_ok;
  assign unused_ok = ^{tag_value_rdata[PAY_W-1:0], hash};
endmodule

// File: tb/tb_pu_tag_insert.sv
module tb_pu_tag_insert;
  localparam int AW = 7, EW = 11, BW = 44, VW = 48;
  localparam logic [2:0] INS = 3'd0, UPD = 3'd1, DEL = 3'd2, FULL = 3'd3, NF = 3'd4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic valid, ready, op;
  logic [31:0] key;
  logic [15:0] pay;
  logic [3:0]  pid;
  logic t0_rd, t0_ack, t0_wr, t1_rd, t1_ack, t1_wr;
  logic [3:0] t0_raddr, t0_waddr, t1_raddr, t1_waddr;
  logic [BW-1:0] t0_rdata, t0_wdata, t1_rdata, t1_wdata;
  logic v_rd, v_ack, v_wr, vack_r, stray_vack;
  logic [AW-1:0] v_raddr, v_waddr;
  logic [VW-1:0] v_rdata, v_wdata;
  logic st_vld;
  logic [2:0] st;
  logic [3:0] st_pid;

  always #5 clk = ~clk;

  pu_tag_insert dut (
    .clk(clk), .rst_n(rst_n),
    .tag_ins_valid(valid), .tag_ins_ready(ready), .tag_ins_op(op), .tag_ins_key(key),
    .tag_ins_payload(pay), .tag_ins_pid(pid),
    .tag_hash_table0_rd(t0_rd), .tag_hash_table0_raddr(t0_raddr), .tag_hash_table0_ack(t0_ack),
    .tag_hash_table0_rdata(t0_rdata), .tag_hash_table0_wr(t0_wr), .tag_hash_table0_waddr(t0_waddr),
    .tag_hash_table0_wdata(t0_wdata),
    .tag_hash_table1_rd(t1_rd), .tag_hash_table1_raddr(t1_raddr), .tag_hash_table1_ack(t1_ack),
    .tag_hash_table1_rdata(t1_rdata), .tag_hash_table1_wr(t1_wr), .tag_hash_table1_waddr(t1_waddr),
    .tag_hash_table1_wdata(t1_wdata),
    .tag_value_rd(v_rd), .tag_value_raddr(v_raddr), .tag_value_ack(v_ack), .tag_value_rdata(v_rdata),
    .tag_value_wr(v_wr), .tag_value_waddr(v_waddr), .tag_value_wdata(v_wdata),
    .tag_ins_status_valid(st_vld), .tag_ins_status(st), .tag_ins_status_pid(st_pid)
  );

  // ---- memory responder: t0 and value acks one cycle after rd, t1 after dly1 cycles
  logic [BW-1:0] t0m [16];
  logic [BW-1:0] t1m [16];
  logic [VW-1:0] vm [128];
  logic mem_clr;
  int dly1 = 1, c1 = 0, cyc = 0;
  logic [3:0] a1;
  int n_vwr = 0, n_b0wr = 0, n_b1wr = 0, n_vrd = 0;

  assign v_ack = vack_r | stray_vack;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    t0_ack <= 1'b0;
    t1_ack <= 1'b0;
    vack_r <= 1'b0;
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) begin t0m[i] <= '0; t1m[i] <= '0; end
      for (int i = 0; i < 128; i++) vm[i] <= '0;
    end else begin
      if (t0_rd) begin t0_ack <= 1'b1; t0_rdata <= t0m[t0_raddr]; end
      if (t1_rd) begin
        if (dly1 <= 1) begin t1_ack <= 1'b1; t1_rdata <= t1m[t1_raddr]; end
        else begin c1 <= dly1 - 1; a1 <= t1_raddr; end
      end else if (c1 == 1) begin t1_ack <= 1'b1; t1_rdata <= t1m[a1]; c1 <= 0; end
      else if (c1 > 1) c1 <= c1 - 1;
      if (v_rd) begin vack_r <= 1'b1; v_rdata <= vm[v_raddr]; n_vrd <= n_vrd + 1; end
      if (v_wr)  begin vm[v_waddr]  <= v_wdata;  n_vwr  <= n_vwr + 1;  end
      if (t0_wr) begin t0m[t0_waddr] <= t0_wdata; n_b0wr <= n_b0wr + 1; end
      if (t1_wr) begin t1m[t1_waddr] <= t1_wdata; n_b1wr <= n_b1wr + 1; end
    end
  end

  // ---- checking
  int n_chk = 0, n_pass = 0, done_cnt = 0, acc_cyc = 0, lat = 0;
  logic [6:0] exp_q [$];

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
  endtask

  always @(negedge clk) if (rst_n && st_vld) begin
    logic [6:0] e;
    chk("status_expected", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("status", 64'(st), 64'(e[6:4]));
      chk("status_pid", 64'(st_pid), 64'(e[3:0]));
    end
    lat = cyc - acc_cyc;
    done_cnt++;
  end

  // ---- reference hash
  function automatic logic [5:0] bh(input logic [31:0] k);
    logic [31:0] r;
    logic [5:0] h;
    r = k; h = '0;
    for (int c = 0; c < 6; c++) begin h ^= r[5:0]; r = r >> 6; end
    return h;
  endfunction
  function automatic logic [3:0] h0i(input logic [31:0] k);
    logic [5:0] h;
    h = bh(k);
    return h[3:0];
  endfunction
  function automatic logic [3:0] h1i(input logic [31:0] k);
    logic [5:0] h;
    logic [31:0] t;
    t = {<<{k}};
    h = bh(t);
    return h[3:0];
  endfunction
  function automatic logic [EW-1:0] slot_of(input logic [BW-1:0] b, input int s);
    return b[s*EW +: EW];
  endfunction

  task automatic req(input logic o, input logic [31:0] k, input logic [15:0] p,
                     input logic [3:0] id, input logic [2:0] exp, input bit junk);
    int t, d0;
    t = 0;
    while (!ready && t < 100) begin @(posedge clk); #1; t++; end
    chk("ready_before_req", 64'(ready), 64'd1);
    op = o; key = k; pay = p; pid = id; valid = 1'b1;
    exp_q.push_back({exp, id});
    acc_cyc = cyc;
    d0 = done_cnt;
    @(posedge clk); #1;
    valid = 1'b0;
    if (junk) begin
      op = 1'b1; key = ~k; valid = 1'b1;
      repeat (4) @(posedge clk);
      #1 valid = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 300) begin @(posedge clk); #1; t++; end
    chk("req_done", 64'(done_cnt != d0), 64'd1);
  endtask

  logic [31:0] ka, kb;
  logic [31:0] fk [7];
  int nf, s_vwr, s_bwr, s_vrd, s_done;

  initial begin
    valid = 0; op = 0; key = 0; pay = 0; pid = 0; stray_vack = 0; mem_clr = 1;
    ka = 0; kb = 0; nf = 0;
    for (int k = 1; ka == 0 && k < 100000; k++) if (h0i(k) == 4'd0) ka = k;
    for (int k = 1; kb == 0 && k < 100000; k++) if (h0i(k) == 4'd5) kb = k;
    for (int k = ka + 1; nf < 7 && k < 1000000; k++)
      if (h0i(k) == 4'd0 && h1i(k) == h1i(ka)) begin fk[nf] = k; nf++; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_status_valid", 64'(st_vld), 64'd0);
    chk("rst_bucket_rd", 64'({t0_rd, t1_rd}), 64'd0);
    chk("rst_writes", 64'({t0_wr, t1_wr, v_wr}), 64'd0);
    chk("rst_value_rd", 64'(v_rd), 64'd0);
    rst_n = 1; mem_clr = 0;
    @(posedge clk); #1;

    // first insert into empty tables: slot0 of bucket0 is reserved -> slot1
    s_vwr = n_vwr; s_bwr = n_b0wr + n_b1wr;
    req(0, ka, 16'd5, 4'd1, INS, 0);
    chk("ins_latency", 64'(lat), 64'd13);
    chk("ins_value", 64'(vm[7'd1]), 64'({ka, 16'd5}));
    chk("ins_entry", 64'(slot_of(t0m[0], 1)), 64'({7'd1, h1i(ka)}));
    chk("ins_vwr_cnt", 64'(n_vwr - s_vwr), 64'd1);
    chk("ins_bwr_cnt", 64'(n_b0wr + n_b1wr - s_bwr), 64'd1);

    // non-zero bucket: slot0 is usable
    req(0, kb, 16'd7, 4'd2, INS, 0);
    chk("insb_value", 64'(vm[{1'b0, 4'd5, 2'd0}]), 64'({kb, 16'd7}));
    chk("insb_entry", 64'(slot_of(t0m[5], 0)), 64'({1'b0, 4'd5, 2'd0, h1i(kb)}));

    // update, with a request held on valid while busy (must be ignored)
    s_vwr = n_vwr; s_bwr = n_b0wr + n_b1wr; s_vrd = n_vrd;
    req(0, ka, 16'd9, 4'd3, UPD, 1);
    chk("upd_vrd_cnt", 64'(n_vrd - s_vrd), 64'd1);
    chk("upd_bwr_cnt", 64'(n_b0wr + n_b1wr - s_bwr), 64'd0);
    chk("upd_vwr_cnt", 64'(n_vwr - s_vwr), 64'd1);
    chk("upd_value", 64'(vm[7'd1]), 64'({ka, 16'd9}));

    // fill the remaining 6 usable slots
    chk("keys_found", 64'(nf), 64'd7);
    for (int i = 0; i < 6; i++) req(0, fk[i], 16'(i + 16), 4'd4, INS, 0);
    chk("fill_t0s3", 64'(slot_of(t0m[0], 3)), 64'({1'b0, 4'd0, 2'd3, h1i(fk[1])}));
    chk("fill_t1s3", 64'(slot_of(t1m[h1i(ka)], 3)), 64'({1'b1, h1i(ka), 2'd3, h0i(fk[5])}));
    chk("fill_value", 64'(vm[{1'b1, h1i(ka), 2'd0}]), 64'({fk[2], 16'd18}));

    s_vwr = n_vwr; s_bwr = n_b0wr + n_b1wr;
    req(0, fk[6], 16'd1, 4'd5, FULL, 0);
    chk("full_writes", 64'(n_vwr - s_vwr + n_b0wr + n_b1wr - s_bwr), 64'd0);

    s_vwr = n_vwr; s_bwr = n_b0wr;
    req(1, ka, 16'hffff, 4'd6, DEL, 0);
    chk("del_value", 64'(vm[7'd1]), 64'({ka, 16'd0}));
    chk("del_entry", 64'(slot_of(t0m[0], 1)), 64'd0);
    chk("del_writes", 64'({n_vwr - s_vwr, n_b0wr - s_bwr}), 64'({32'd1, 32'd1}));

    s_vwr = n_vwr; s_bwr = n_b0wr + n_b1wr;
    req(1, ka, 16'd0, 4'd7, NF, 0);
    chk("nf_writes", 64'(n_vwr - s_vwr + n_b0wr + n_b1wr - s_bwr), 64'd0);

    // table1 ack three cycles after table0, stray value ack while idle
    dly1 = 4;
    stray_vack = 1; @(posedge clk); #1; stray_vack = 0;
    @(posedge clk); #1;
    chk("stray_ready", 64'(ready), 64'd1);
    req(0, ka, 16'd3, 4'd8, INS, 0);
    chk("dly_value", 64'(vm[7'd1]), 64'({ka, 16'd3}));
    chk("dly_entry", 64'(slot_of(t0m[0], 1)), 64'({7'd1, h1i(ka)}));
    dly1 = 1;

    // reset while waiting on the value read
    s_vwr = n_vwr; s_bwr = n_b0wr + n_b1wr; s_done = done_cnt;
    op = 0; key = ka; pay = 16'd7; pid = 4'd9; valid = 1;
    @(posedge clk); #1; valid = 0;
    begin
      int t;
      t = 0;
      while (!v_rd && t < 60) begin @(posedge clk); #1; t++; end
      chk("vrd_seen", 64'(v_rd), 64'd1);
    end
    rst_n = 0; #1;
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_status", 64'(st_vld), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_writes", 64'(n_vwr - s_vwr + n_b0wr + n_b1wr - s_bwr), 64'd0);
    chk("midrst_no_status", 64'(done_cnt - s_done), 64'd0);

    req(0, ka, 16'd7, 4'd10, UPD, 0);
    chk("post_rst_value", 64'(vm[7'd1]), 64'({ka, 16'd7}));
    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
